codebreaker_switch_ctrl: RTL and testbench

Controller for the slide-switch input bank: synchronises and debounces the 10 raw switch lines, captures debounced edges, and raises a maskable interrupt. Exposed to the Nios II as an Avalon-MM slave with a 4-word register map and read latency 1. It replaces the bare switch PIO so that software gets clean, event-driven code entry.

---
 rtl/codebreaker_switch_ctrl.sv | 90 +++++++++
 tb/tb_codebreaker_switch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/codebreaker_switch_ctrl.sv
// Slide-switch controller: two-flop synchroniser, per-bit debounce, edge capture
// with maskable level interrupt, and a four-word Avalon-MM register map (read latency 1).
module codebreaker_switch_ctrl #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] debounced_reg;
    logic [WIDTH-1:0] edge_capture_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [CNT_W-1:0] cnt_reg  [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] level_match;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clear;
    logic [31:0]      readdata_reg;
    logic [31:0]      readdata_next;
    logic             wr_en;
    logic             unused_writedata;

    assign wr_en            = chipselect && !write_n;
    assign edge_clear       = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    assign unused_writedata = ^writedata;

    // Each bit counts consecutive clocks of disagreement; any agreement restarts it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            assign level_match[gi] = (sync2_reg[gi] == debounced_reg[gi]);
            assign edge_set[gi]    = !level_match[gi] && (cnt_reg[gi] == CNT_LAST);
            assign cnt_next[gi]    = (level_match[gi] || edge_set[gi]) ? '0
                                   : cnt_reg[gi] + CNT_W'(1);
        end
    endgenerate

    always_comb begin
        readdata_next = '0;
        case (address)
            2'd0:    readdata_next[WIDTH-1:0] = debounced_reg;
            2'd1:    readdata_next[WIDTH-1:0] = irq_mask_reg;
            2'd2:    readdata_next[WIDTH-1:0] = edge_capture_reg;
            default: readdata_next[WIDTH-1:0] = sync2_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg        <= '0;
            sync2_reg        <= '0;
            debounced_reg    <= '0;
            edge_capture_reg <= '0;
            irq_mask_reg     <= '0;
            readdata_reg     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            sync1_reg     <= in_port;
            sync2_reg     <= sync1_reg;
            debounced_reg <= debounced_reg ^ edge_set;
            // A new edge outranks a simultaneous write-one-to-clear.
            edge_capture_reg <= (edge_capture_reg & ~edge_clear) | edge_set;
            if (wr_en && address == 2'd1) begin
                irq_mask_reg <= writedata[WIDTH-1:0];
            end
            readdata_reg <= readdata_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_codebreaker_switch_ctrl.sv
// Randomised bench for codebreaker_switch_ctrl against a window-based behavioural model.
module tb_codebreaker_switch_ctrl;

    localparam int W  = 10;
    localparam int DC = 4;

    logic          clk;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a level is accepted once the last DC synchronised samples all disagree with it.
    logic [W-1:0]  m_s1, m_s2, m_deb, m_edge, m_mask;
    logic [W-1:0]  m_win [DC];
    logic [31:0]   m_rd;
    logic          m_irq;

    codebreaker_switch_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_edge = '0; m_mask = '0;
        m_rd = '0; m_irq = 1'b0;
        for (int k = 0; k < DC; k++) m_win[k] = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [W-1:0] set_v, clr_v;
        logic [31:0]  rd_v;
        logic         all_diff, wr;
        rd_v = '0;
        case (address)
            2'd0:    rd_v[W-1:0] = m_deb;
            2'd1:    rd_v[W-1:0] = m_mask;
            2'd2:    rd_v[W-1:0] = m_edge;
            default: rd_v[W-1:0] = m_s2;
        endcase
        for (int k = DC - 1; k > 0; k--) m_win[k] = m_win[k-1];
        m_win[0] = m_s2;
        set_v = '0;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DC; k++) if (m_win[k][i] == m_deb[i]) all_diff = 1'b0;
            set_v[i] = all_diff;
        end
        m_deb  = m_deb ^ set_v;
        wr     = chipselect && !write_n;
        clr_v  = (wr && address == 2'd2) ? writedata[W-1:0] : '0;
        m_edge = (m_edge & ~clr_v) | set_v;
        if (wr && address == 2'd1) m_mask = writedata[W-1:0];
        m_s2  = m_s1;
        m_s1  = in_port;
        m_rd  = rd_v;
        m_irq = |(m_edge & m_mask);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("rd", readdata, m_rd);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        $display("write addr=%0d data=0x%08h irq=%0b", a, d, irq);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        tick();
        $display("read  addr=%0d data=0x%08h irq=%0b", a, readdata, irq);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_rd", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; in_port = '0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        model_reset();
        #2;
        do_reset(10);

        // 1: reset state, then a clean step on bit 3
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            check("t1_rd_zero", readdata, 32'h0);
        end
        in_port[3] = 1'b1;
        address = 2'd0;
        repeat (DC + 2) tick();
        bus_read(2'd0);
        check("t1_data", readdata, 32'h008);
        bus_read(2'd2);
        check("t1_edge", readdata, 32'h008);
        check("t1_irq", {31'b0, irq}, 32'h0);

        // 2: glitch shorter than the debounce window, then a held level
        bus_write(2'd1, 32'h3FF);
        in_port[0] = 1'b1;
        repeat (3) tick();
        in_port[0] = 1'b0;
        repeat (8) tick();
        bus_read(2'd0);
        check("t2_glitch_data", readdata, 32'h008);
        bus_read(2'd2);
        check("t2_glitch_edge", readdata, 32'h008);
        in_port[0] = 1'b1;
        repeat (10) tick();
        bus_read(2'd2);
        check("t2_edge", readdata, 32'h009);
        check("t2_irq", {31'b0, irq}, 32'h1);

        // 3: write-one-to-clear
        bus_write(2'd2, 32'h001);
        bus_read(2'd2);
        check("t3_edge", readdata, 32'h008);
        check("t3_irq_hold", {31'b0, irq}, 32'h1);
        bus_write(2'd2, 32'h008);
        check("t3_irq_clr", {31'b0, irq}, 32'h0);
        bus_read(2'd2);
        check("t3_edge_zero", readdata, 32'h0);

        // 4: debounce completion on bit 5 in the same cycle as its clear
        in_port[5] = 1'b1;
        address = 2'd0;
        repeat (DC + 1) tick();
        bus_write(2'd2, 32'h020);
        bus_read(2'd2);
        check("t4_set_wins", readdata, 32'h020);

        // 5: mask width, read-only registers, raw view
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        check("t5_mask", readdata, 32'h3FF);
        bus_write(2'd0, 32'h155);
        bus_write(2'd3, 32'h155);
        bus_read(2'd0);
        check("t5_data_ro", readdata, 32'h029);
        in_port = 10'h0F0;
        address = 2'd3;
        repeat (2) tick();
        bus_read(2'd3);
        check("t5_raw", readdata, 32'h0F0);
        repeat (10) tick();

        // 6: reset in the middle of a debounce
        in_port = 10'h3FF;
        address = 2'd0;
        repeat (4) tick();
        do_reset(1);
        repeat (6) tick();
        bus_read(2'd0);
        check("t6_data", readdata, 32'h3FF);
        bus_read(2'd2);
        check("t6_edge", readdata, 32'h3FF);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ (10'd1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 15) == 0) in_port = 10'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset(1);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            tick();
            $display("rand  n=%0d in=0x%03h addr=%0d cs=%0b wn=%0b rd=0x%08h irq=%0b",
                     n, in_port, address, chipselect, write_n, readdata, irq);
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
